// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Instruction/PC buffer; head is registered, visible the cycle after the push that fills it.
// No internal backpressure: flush beats push, pop is honoured alongside flush, head holds when empty.
module fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                 DEPTH      = 2,
    parameter logic [ENTRY_W-1:0] RESET_HEAD = '0,
    localparam int                AW         = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_dat,
    input  logic               pop,
    input  logic               flush,
    output logic [ENTRY_W-1:0] head_dat,
    output logic               full,
    output logic               empty,
    output logic [AW:0]        count
);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   remain;
    logic [AW:0]   count_nxt;
    logic          do_pop;
    logic          do_push;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & ~flush & (~full | do_pop);
    assign remain    = count - (AW+1)'(do_pop);
    assign count_nxt = flush ? '0 : remain + (AW+1)'(do_push);
    assign rd_nxt    = rd_ptr + AW'(do_pop);
    assign head_dat  = head;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= RESET_HEAD;
        end else begin
            count <= count_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_nxt;
                if (do_push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
            end
            // A FIFO that drains to empty before this push makes the pushed entry the new head.
            if (count_nxt != '0) begin
                head <= (remain == '0) ? fetch_entry_t'(push_dat) : mem[rd_nxt];
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: issues word reads, buffers returns, presents them to the core; 2-cycle fetch-to-valid with 1-cycle memory.
// Requests only while outstanding plus buffered entries leave room; redirects flush and drop in-flight data.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          credit;
    logic          fire;
    logic          rsp_push;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  head_e;

    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit    = (in_use < (CW+1)'(DEPTH));
    assign imem_req  = reset_n & credit & ~redirect_valid;
    assign imem_addr = fetch_pc;
    assign fire      = imem_req & imem_gnt;
    assign rsp_push  = imem_rvalid & ~redirect_valid & (drop_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                fetch_pc <= redirect_pc & WORD_MASK;
                resp_pc  <= redirect_pc & WORD_MASK;
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rvalid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH),
        .RESET_HEAD ({32'h0, RESET_PC})
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (rsp_push),
        .push_dat ({imem_rdata, resp_pc}),
        .pop      (if_ready),
        .flush    (redirect_valid),
        .head_dat (head_e),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign if_valid    = ~fifo_empty;
    assign if_instr    = head_e.instr;
    assign if_pc       = head_e.pc;
    assign if_pc_plus4 = head_e.pc + 32'd4;

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        rsp_push |-> (!fifo_full || if_ready));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit with an epoch-tagged memory/queue reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          cyc;
    } ev_t;

    mreq_t       mq[$];
    logic [31:0] fq[$];
    ev_t         req_log[$];
    ev_t         pop_log[$];

    int          cyc = 0;
    int          epoch = 0;
    int          redir_cyc = -100;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pc = RESET_PC;
    logic [31:0] last_instr = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          redir_pct = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_tgt = 32'h0;
    logic        obs_req = 1'b0;
    logic        obs_valid = 1'b0;
    logic [31:0] obs_addr = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, compare 1ns later, then advance the model.
    task automatic cycle();
        mreq_t e;
        logic  rv;
        logic  exp_req;
        @(negedge clk);
        if (!reset_n) begin
            mq.delete();
            fq.delete();
            exp_pc      = RESET_PC;
            last_pc     = RESET_PC;
            last_instr  = 32'h0;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            redirect_valid = 1'b0;
            if_ready    = 1'b0;
            #1;
            check1("rst_imem_req", imem_req, 1'b0);
            check1("rst_if_valid", if_valid, 1'b0);
            check32("rst_if_pc", if_pc, RESET_PC);
            check32("rst_if_instr", if_instr, 32'h0);
            check32("rst_if_pc_plus4", if_pc_plus4, RESET_PC + 32'd4);
        end else begin
            rv = (mq.size() > 0) && (mq[0].due <= cyc);
            imem_rvalid = rv;
            imem_rdata  = rv ? instr_of(mq[0].addr) : $urandom();
            imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
            if_ready    = ($urandom_range(0, 99) < ready_pct);
            if (force_redir) begin
                redirect_valid = 1'b1;
                redirect_pc    = force_tgt;
                force_redir    = 1'b0;
            end else begin
                redirect_valid = ($urandom_range(0, 99) < redir_pct);
                redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF6 : $urandom();
            end
            #1;
            exp_req = ((mq.size() + fq.size()) < DEPTH) && !redirect_valid;
            check1("imem_req", imem_req, exp_req);
            if (exp_req && imem_req) check32("imem_addr", imem_addr, exp_pc);
            check1("if_valid", if_valid, fq.size() > 0);
            if (fq.size() > 0) begin
                last_pc    = fq[0];
                last_instr = instr_of(fq[0]);
            end
            check32("if_pc", if_pc, last_pc);
            check32("if_instr", if_instr, last_instr);
            check32("if_pc_plus4", if_pc_plus4, last_pc + 32'd4);
            obs_req   = imem_req;
            obs_addr  = imem_addr;
            obs_valid = if_valid;

            if (if_valid && if_ready) pop_log.push_back('{pc: if_pc, instr: if_instr, cyc: cyc});
            if (if_ready && fq.size() > 0) fq.delete(0);
            if (rv) begin
                e = mq.pop_front();
                if (!redirect_valid && e.epoch == epoch) fq.push_back(e.pc);
            end
            if (imem_req && imem_gnt) begin
                req_log.push_back('{pc: imem_addr, instr: 32'h0, cyc: cyc});
                e.addr  = imem_addr;
                e.pc    = exp_pc;
                e.epoch = epoch;
                e.due   = cyc + lat_min + int'($urandom_range(0, lat_max - lat_min));
                mq.push_back(e);
                if (!redirect_valid) exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                fq.delete();
                epoch++;
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
                redir_cyc = cyc;
            end
        end
        cyc++;
        @(posedge clk);
    endtask

    task automatic apply_reset();
        #3 reset_n = 1'b0;
        cycle();
        cycle();
        #3 reset_n = 1'b1;
        req_log.delete();
        pop_log.delete();
        cyc = 0;
    endtask

    task automatic wait_reqs(input int n, input string name);
        int k = 0;
        while (req_log.size() < n && k < 40) begin
            cycle();
            k++;
        end
        check32(name, 32'(req_log.size()), 32'(n));
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int g, input int r, input int d);
        lat_min = lmin; lat_max = lmax; gnt_pct = g; ready_pct = r; redir_pct = d;
    endtask

    initial begin
        int k;

        // Streaming with a 1-cycle memory
        set_knobs(1, 1, 100, 100, 0);
        apply_reset();
        repeat (12) cycle();
        check1("p1_enough", req_log.size() >= 3 && pop_log.size() >= 2, 1'b1);
        check32("p1_req0", req_log[0].pc, 32'h0);
        check32("p1_req1", req_log[1].pc, 32'h4);
        check32("p1_req2", req_log[2].pc, 32'h8);
        check32("p1_req1_cyc", 32'(req_log[1].cyc), 32'(req_log[0].cyc + 1));
        check32("p1_pop0_pc", pop_log[0].pc, 32'h0);
        check32("p1_pop0_instr", pop_log[0].instr, instr_of(32'h0));
        check32("p1_pop0_cyc", 32'(pop_log[0].cyc), 32'(req_log[0].cyc + 2));
        check32("p1_pop1_pc", pop_log[1].pc, 32'h4);
        check32("p1_pop1_cyc", 32'(pop_log[1].cyc), 32'(pop_log[0].cyc + 1));

        // Backpressure
        set_knobs(1, 1, 100, 0, 0);
        apply_reset();
        repeat (10) cycle();
        #1;
        check32("p2_nreq", 32'(req_log.size()), 32'd2);
        check1("p2_if_valid", if_valid, 1'b1);
        check32("p2_if_pc", if_pc, 32'h0);
        ready_pct = 100;
        repeat (10) cycle();
        check1("p2_enough", pop_log.size() >= 3 && req_log.size() >= 3, 1'b1);
        check32("p2_pop0", pop_log[0].pc, 32'h0);
        check32("p2_pop1", pop_log[1].pc, 32'h4);
        check32("p2_pop2", pop_log[2].pc, 32'h8);
        check32("p2_req2", req_log[2].pc, 32'h8);

        // Redirect with two requests in flight on a 3-cycle memory
        set_knobs(3, 3, 100, 100, 0);
        apply_reset();
        wait_reqs(2, "p3_wait");
        force_tgt   = 32'h0000_1003;
        force_redir = 1'b1;
        repeat (15) cycle();
        check1("p3_enough", req_log.size() >= 3 && pop_log.size() >= 1, 1'b1);
        check32("p3_req_target", req_log[2].pc, 32'h0000_1000);
        check32("p3_first_pc", pop_log[0].pc, 32'h0000_1000);
        check32("p3_first_instr", pop_log[0].instr, instr_of(32'h0000_1000));
        check1("p3_penalty", (pop_log[0].cyc - redir_cyc) >= 3, 1'b1);

        // Grant withheld
        set_knobs(1, 1, 100, 100, 0);
        apply_reset();
        wait_reqs(2, "p4_wait");
        gnt_pct = 0;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!obs_req && k < 10);
        check1("p4_req_seen", obs_req, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check1("p4_req_hold", obs_req, 1'b1);
            check32("p4_addr_hold", obs_addr, 32'h8);
        end
        gnt_pct = 100;
        repeat (6) cycle();
        check1("p4_enough", req_log.size() >= 4, 1'b1);
        check32("p4_req2", req_log[2].pc, 32'h8);
        check32("p4_req3", req_log[3].pc, 32'hC);

        // Pop, rvalid and redirect all in one cycle
        set_knobs(1, 1, 100, 100, 0);
        apply_reset();
        wait_reqs(2, "p5_wait");
        force_tgt   = 32'h0000_2000;
        force_redir = 1'b1;
        cycle();
        cycle();
        check1("p5_empty_after", obs_valid, 1'b0);
        check1("p5_req", obs_req, 1'b1);
        check32("p5_addr", obs_addr, 32'h0000_2000);
        repeat (5) cycle();
        check1("p5_enough", pop_log.size() >= 2 && req_log.size() >= 3, 1'b1);
        check32("p5_pop_honoured", pop_log[0].pc, 32'h0);
        check32("p5_pop_cyc", 32'(pop_log[0].cyc), 32'(redir_cyc));
        check32("p5_req_cyc", 32'(req_log[2].cyc), 32'(redir_cyc + 1));
        check32("p5_next_pc", pop_log[1].pc, 32'h0000_2000);
        check32("p5_next_cyc", 32'(pop_log[1].cyc), 32'(redir_cyc + 3));

        // Asynchronous reset with two fetches in flight
        set_knobs(3, 3, 100, 100, 0);
        apply_reset();
        repeat (20) cycle();
        k = 0;
        while (mq.size() != 2 && k < 60) begin
            cycle();
            k++;
        end
        check32("p6_inflight", 32'(mq.size()), 32'd2);
        #3 reset_n = 1'b0;
        #1;
        check1("p6_async_req", imem_req, 1'b0);
        check1("p6_async_valid", if_valid, 1'b0);
        check32("p6_async_pc", if_pc, RESET_PC);
        check32("p6_async_pc4", if_pc_plus4, RESET_PC + 32'd4);
        check32("p6_async_instr", if_instr, 32'h0);
        cycle();
        cycle();
        #3 reset_n = 1'b1;
        req_log.delete();
        pop_log.delete();
        cyc = 0;
        set_knobs(1, 1, 100, 100, 0);
        repeat (10) cycle();
        check1("p6_enough", req_log.size() >= 1 && pop_log.size() >= 1, 1'b1);
        check32("p6_restart_req", req_log[0].pc, RESET_PC);
        check32("p6_restart_pop", pop_log[0].pc, RESET_PC);

        // Randomised traffic
        for (int p = 0; p < 20; p++) begin
            k = int'($urandom_range(1, 4));
            set_knobs(k, k + int'($urandom_range(0, 2)), int'($urandom_range(30, 100)),
                      int'($urandom_range(20, 100)), int'($urandom_range(0, 8)));
            if (p % 5 == 4) apply_reset();
            repeat (150) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
